uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/UART-FIFO bundle for the transmit arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_full;
    logic                         tx_write;
    logic [DATA_BITS-1:0]         tx_data;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;
    logic                         timeout;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_write, tx_data, grant_id, busy, timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_write, tx_data, grant_id, busy, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX FIFO among requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BW   = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]      state;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] last_grant;
    logic [BW-1:0]   burst_cnt;
    logic [7:0]      stall_cnt;

    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    int              idx;

    logic            busy;
    logic            owner_valid;
    logic            fire;
    logic [BW-1:0]   burst_next;
    logic            burst_done;
    logic            stall_hit;

    // Rotating priority: search starts just past the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    assign busy        = (state == S_XFER);
    assign owner_valid = bus.req_valid[grant_q];
    assign fire        = busy && owner_valid && !bus.tx_full;
    assign burst_next  = burst_cnt + BW'(1);
    assign burst_done  = (burst_next == BW'(MAX_BURST));
    assign stall_hit   = ((stall_cnt + 8'd1) == 8'(IDLE_TIMEOUT));

    always_comb begin
        bus.req_ready = '0;
        if (busy && !bus.tx_full) begin
            bus.req_ready[grant_q] = 1'b1;
        end
    end

    assign bus.tx_write = fire;
    assign bus.tx_data  = fire ? bus.req_data[grant_q*DATA_BITS +: DATA_BITS] : '0;
    assign bus.grant_id = busy ? grant_q : '0;
    assign bus.busy     = busy;
    // A stall cycle never carries a transfer, so a transfer always beats the timeout.
    assign bus.timeout  = busy && !owner_valid && stall_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant_q    <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state     <= S_XFER;
                        grant_q   <= pick_id;
                        burst_cnt <= '0;
                        stall_cnt <= '0;
                    end
                end
                S_XFER: begin
                    if (fire) begin
                        stall_cnt <= '0;
                        burst_cnt <= burst_next;
                        if (bus.req_last[grant_q] || burst_done) begin
                            state      <= S_IDLE;
                            last_grant <= grant_q;
                        end
                    end else if (!owner_valid) begin
                        if (stall_hit) begin
                            state      <= S_IDLE;
                            last_grant <= grant_q;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(4), .IDLE_TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[i]      = v;
        bus.req_data[i*8 +: 8] = d;
        bus.req_last[i]       = l;
    endtask

    task automatic clear_inputs;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        bus.req_valid = 4'hF;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_write", bus.tx_write, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_data", bus.tx_data, 0);
        clear_inputs();
        rst_n = 1'b1;

        // single requester 2, three characters
        tick();
        drive(2, 1, 8'h41, 0);
        #1;
        chk("r2_idle_busy", bus.busy, 0);
        chk("r2_idle_write", bus.tx_write, 0);
        tick();
        chk("r2_grant", bus.grant_id, 2);
        chk("r2_ready", bus.req_ready, 4'b0100);
        chk("r2_w0", bus.tx_write, 1);
        chk("r2_d0", bus.tx_data, 8'h41);
        tick();
        drive(2, 1, 8'h42, 0);
        #1;
        chk("r2_w1", bus.tx_write, 1);
        chk("r2_d1", bus.tx_data, 8'h42);
        tick();
        drive(2, 1, 8'h43, 1);
        #1;
        chk("r2_w2", bus.tx_write, 1);
        chk("r2_d2", bus.tx_data, 8'h43);
        tick();
        drive(2, 0, 8'h00, 0);
        #1;
        chk("r2_end_busy", bus.busy, 0);
        chk("r2_end_write", bus.tx_write, 0);

        // round robin with all four requesting 1-char messages
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 1, 8'(8'h10 + i), 1);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_idle", bus.busy, 0);
            tick();
            chk("rr_grant", bus.grant_id, k % 4);
            chk("rr_data", bus.tx_data, 8'h10 + (k % 4));
            tick();
        end
        clear_inputs();

        // burst limit: req 1 six chars, req 3 two chars
        do_reset();
        drive(1, 1, 8'hA0, 0);
        drive(3, 1, 8'h30, 0);
        #1;
        chk("bl_idle0", bus.busy, 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 8'(8'hA0 + c), 0);
            #1;
            chk("bl_grant1", bus.grant_id, 1);
            chk("bl_data1", bus.tx_data, 8'hA0 + c);
            chk("bl_ready1", bus.req_ready, 4'b0010);
            tick();
        end
        drive(1, 1, 8'hA4, 0);
        #1;
        chk("bl_idle1", bus.busy, 0);
        tick();
        chk("bl_grant3", bus.grant_id, 3);
        chk("bl_data30", bus.tx_data, 8'h30);
        tick();
        drive(3, 1, 8'h31, 1);
        #1;
        chk("bl_data31", bus.tx_data, 8'h31);
        tick();
        drive(3, 0, 8'h00, 0);
        #1;
        chk("bl_idle2", bus.busy, 0);
        tick();
        chk("bl_regrant1", bus.grant_id, 1);
        chk("bl_dataA4", bus.tx_data, 8'hA4);
        tick();
        drive(1, 1, 8'hA5, 1);
        #1;
        chk("bl_dataA5", bus.tx_data, 8'hA5);
        tick();
        drive(1, 0, 8'h00, 0);
        #1;
        chk("bl_idle3", bus.busy, 0);

        // TX FIFO full for 20 cycles: grant held, no timeout
        bus.tx_full = 1'b1;
        drive(0, 1, 8'h55, 1);
        #1;
        chk("ff_idle", bus.busy, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("ff_nowrite", bus.tx_write, 0);
            chk("ff_notimeout", bus.timeout, 0);
            chk("ff_busy", bus.busy, 1);
            chk("ff_noready", bus.req_ready, 0);
            tick();
        end
        bus.tx_full = 1'b0;
        #1;
        chk("ff_write", bus.tx_write, 1);
        chk("ff_data", bus.tx_data, 8'h55);
        chk("ff_ready", bus.req_ready, 4'b0001);
        tick();
        drive(0, 0, 8'h00, 0);
        #1;
        chk("ff_end", bus.busy, 0);

        // owner stalls after one char; timeout then req 3 gets the grant
        drive(2, 1, 8'h61, 0);
        drive(3, 1, 8'h70, 0);
        #1;
        chk("to_idle", bus.busy, 0);
        tick();
        chk("to_grant2", bus.grant_id, 2);
        chk("to_data61", bus.tx_data, 8'h61);
        tick();
        drive(2, 0, 8'h00, 0);
        for (int k = 1; k < 16; k++) begin
            #1;
            chk("to_early", bus.timeout, 0);
            chk("to_hold", bus.grant_id, 2);
            tick();
        end
        #1;
        chk("to_pulse", bus.timeout, 1);
        chk("to_pulse_busy", bus.busy, 1);
        tick();
        chk("to_after", bus.timeout, 0);
        chk("to_after_busy", bus.busy, 0);
        tick();
        drive(3, 1, 8'h77, 1);
        #1;
        chk("to_grant3", bus.grant_id, 3);
        chk("to_data77", bus.tx_data, 8'h77);
        tick();
        drive(3, 0, 8'h00, 0);
        #1;
        chk("to_end", bus.busy, 0);

        // reset during second character of req 0
        drive(0, 1, 8'h01, 0);
        drive(1, 1, 8'h11, 1);
        tick();
        chk("ar_grant0", bus.grant_id, 0);
        chk("ar_data01", bus.tx_data, 8'h01);
        tick();
        drive(0, 1, 8'h02, 0);
        #1;
        chk("ar_write2", bus.tx_write, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_write", bus.tx_write, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_ready", bus.req_ready, 0);
        chk("ar_data", bus.tx_data, 0);
        chk("ar_grant", bus.grant_id, 0);
        chk("ar_timeout", bus.timeout, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_rel_idle", bus.busy, 0);
        tick();
        chk("ar_regrant_busy", bus.busy, 1);
        chk("ar_regrant0", bus.grant_id, 0);
        chk("ar_regrant_data", bus.tx_data, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
